// File: rtl/jk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_pkg: shared state encoding and J/K excitation for jk_reg_writer |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_e;

  function automatic int retry_width(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Returns {j, k} for one bit: set/reset drive ignores q, toggle drive flips only differing bits.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic use_toggle);
    if (use_toggle) begin
      return {q ^ t, q ^ t};
    end
    return {t, ~t};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_excite_bit: combinational J/K drive for one bank bit            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module jk_excite_bit
  import jk_pkg::*;
#(
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  assign {j, k} = jk_excite(q, t, USE_TOGGLE);

endmodule
`default_nettype wire

// File: rtl/jk_reg_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_reg_writer: drives a JK bank to a target word, verifies via q   |
// | feedback with bounded retries. Revision: 1.0                       |
// +--------------------------------------------------------------------+
module jk_reg_writer
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  output logic             done,
  output logic             err
);

  localparam int            RW          = retry_width(MAX_RETRY);
  localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             en_q, en_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] w_t, w_j, w_k;

  // In IDLE the excitation is for the word being accepted; otherwise for the held target.
  assign w_t = (state_q == IDLE) ? wr_data : target_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_excite_bit #(.USE_TOGGLE(USE_TOGGLE != 0)) u_bit (
        .q (q_fb[i]),
        .t (w_t[i]),
        .j (w_j[i]),
        .k (w_k[i])
      );
    end
  endgenerate

  assign wr_ready = (state_q == IDLE) && rst_n;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready) begin
          target_d = wr_data;
          j_d      = w_j;
          k_d      = w_k;
          en_d     = 1'b1;
          state_d  = APPLY;
        end
      end
      APPLY:   state_d = RELEASE;
      RELEASE: state_d = CHECK;
      CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          retry_d = '0;
          state_d = IDLE;
        end else if (retry_q < C_MAX_RETRY) begin
          retry_d = retry_q + RW'(1);
          j_d     = w_j;
          k_d     = w_k;
          en_d    = 1'b1;
          state_d = APPLY;
        end else begin
          err_d   = 1'b1;
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      retry_q  <= '0;
      j_q      <= '0;
      k_q      <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      j_q      <= j_d;
      k_q      <= k_d;
      en_q     <= en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign en   = en_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire
